// File: rtl/xor_frame_parity_if.sv
// Handshake bundle for the streaming XOR frame parity engine.
// The slave side is the parity engine; the master side is the word source
// together with the result sink.
interface xor_frame_parity_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 16
);
  localparam int CW = $clog2(MAX_WORDS + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;
  logic             out_bit;
  logic [CW-1:0]    out_count;
  logic             out_overflow;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_bit, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_word, out_bit, out_count, out_overflow
  );
endinterface

// File: rtl/xor_frame_parity.sv
// Streaming XOR parity engine: folds each accepted word of a frame into a
// column-wise XOR, then holds the column parity word, reduction parity bit,
// saturating word count and overflow flag until the sink takes them.
module xor_frame_parity #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 16,
  parameter int ODD       = 0,
  localparam int CW       = $clog2(MAX_WORDS + 1)
) (
  input logic               clk,
  input logic               rst,
  xor_frame_parity_if.slave bus
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic          ODD_BIT = (ODD != 0) ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WORDS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Reduction parity of one word (even sense).
  function automatic logic parity_of(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             ovf;
  logic             ovf_next;
  logic [WIDTH-1:0] res_word;
  logic [WIDTH-1:0] res_word_next;
  logic             res_bit;
  logic             res_bit_next;
  logic [CW-1:0]    res_count;
  logic [CW-1:0]    res_count_next;
  logic             res_ovf;
  logic             res_ovf_next;

  logic [WIDTH-1:0] fold;
  logic [CW-1:0]    cnt_sat;
  logic             ovf_upd;

  // Running values as they would look after folding in the word on in_data.
  always_comb begin
    fold    = acc ^ bus.in_data;
    cnt_sat = (cnt == CNT_MAX) ? CNT_MAX : (cnt + CNT_ONE);
    ovf_upd = ovf | (cnt == CNT_MAX);
  end

  // Next-state and next-datapath decision for the ACCUM/HOLD controller.
  always_comb begin
    state_next     = state;
    acc_next       = acc;
    cnt_next       = cnt;
    ovf_next       = ovf;
    res_word_next  = res_word;
    res_bit_next   = res_bit;
    res_count_next = res_count;
    res_ovf_next   = res_ovf;
    case (state)
      ACCUM: begin
        if (bus.in_valid) begin
          if (bus.in_last) begin
            res_word_next  = fold;
            res_bit_next   = parity_of(fold) ^ ODD_BIT;
            res_count_next = cnt_sat;
            res_ovf_next   = ovf_upd;
            acc_next       = '0;
            cnt_next       = '0;
            ovf_next       = 1'b0;
            state_next     = HOLD;
          end else begin
            acc_next = fold;
            cnt_next = cnt_sat;
            ovf_next = ovf_upd;
          end
        end else begin
          state_next = ACCUM;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_next = ACCUM;
        end else begin
          state_next = HOLD;
        end
      end
      default: begin
        state_next = ACCUM;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial frame or result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      res_word  <= '0;
      res_bit   <= 1'b0;
      res_count <= '0;
      res_ovf   <= 1'b0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      cnt       <= cnt_next;
      ovf       <= ovf_next;
      res_word  <= res_word_next;
      res_bit   <= res_bit_next;
      res_count <= res_count_next;
      res_ovf   <= res_ovf_next;
    end
  end

  // Handshake flags are pure decodes of the state register.
  assign bus.in_ready     = (state == ACCUM);
  assign bus.out_valid    = (state == HOLD);
  assign bus.out_word     = res_word;
  assign bus.out_bit      = res_bit;
  assign bus.out_count    = res_count;
  assign bus.out_overflow = res_ovf;

endmodule
